tile_config_mem_sync: RTL and testbench
=======================================

# tile_config_mem_sync

Clocked, double-buffered successor to the per-tile frame-latch configuration memory. Frames arriving on `FrameData`/`FrameStrobe` from the column frame controller are captured into a shadow store on strobe rising edges. A single `Commit` pulse transfers the whole shadow image to the active store that drives `ConfigBits`/`ConfigBits_N`, so a tile is reconfigured atomically. The block also provides per-frame load tracking, strobe-error detection and single-cycle readback of either store; it sits in every tile, between the frame distribution network and the tile's switch matrix and BELs.

## Interface
- `MaxFramesPerCol`, 20, number of frame strobe lines per column
- `FrameBitsPerRow`, 32, frame data width
- `NoConfigBits`, 640, configuration bits used by this tile
  - legal range is 1..`MaxFramesPerCol*FrameBitsPerRow`
  - NumFrames = ceil(`NoConfigBits`/`FrameBitsPerRow`)
- `RbIdxW`, `$clog2(MaxFramesPerCol)`, width of the readback frame index
- `CLK`, in, 1: the single clock; all state updates on its rising edge
- `resetn`, in, 1: asynchronous, active-low reset
- `FrameData`, in, `FrameBitsPerRow`: frame payload
- `FrameStrobe`, in, `MaxFramesPerCol`: level strobes, nominally one-hot; a write is triggered by a rising edge
- `Commit`, in, 1: single-cycle pulse that copies shadow to active
- `ClearErr`, in, 1: clears `StrobeErr`
- `RbReq`, in, 1: readback request
- `RbFrame`, in, `RbIdxW`: frame index to read back
- `RbSel`, in, 1: readback source; 0 = shadow, 1 = active
- `ConfigBits`, out, `NoConfigBits`: active configuration
- `ConfigBits_N`, out, `NoConfigBits`: bitwise inverse of `ConfigBits`
- `LoadedMask`, out, NumFrames: per-frame written-since-commit flags
- `AllLoaded`, out, 1: AND of `LoadedMask`
- `StrobeErr`, out, 1: sticky multi-hot strobe error
- `RbValid`, out, 1: readback data valid
- `RbData`, out, `FrameBitsPerRow`: readback data

## Operation
- Bit mapping: frame f, bit b maps to config index f*`FrameBitsPerRow`+b.
  - Indices ≥ `NoConfigBits` are discarded on write and read back as 0.
- Edge detect: `strb_q` registers `FrameStrobe` every cycle. `rise = FrameStrobe & ~strb_q`. Only strobe lines below NumFrames participate.
- Write:
  - Exactly one `rise` bit f set: the shadow frame f is loaded with `FrameData` and `LoadedMask[f]` is set.
  - Zero bits set: nothing happens.
  - Two or more bits set: no shadow change and no mask change; `StrobeErr` is set.
  - A strobe held high writes once only; a new write requires the strobe to fall and rise again.
- `StrobeErr` stays set until `ClearErr` or reset. If `ClearErr` and a new error occur in the same cycle, the error wins (flag stays 1).
- Commit:
  - The active store loads the shadow contents present before this edge. A write in the same cycle lands in shadow only.
  - `LoadedMask` is cleared, except the bit of a frame written in that same cycle, which is set.
  - The shadow store is retained, not cleared, so partial reconfiguration needs only the changed frames.
- Readback:
  - When `RbReq` is sampled high, the next cycle presents `RbValid`=1 and `RbData` = the selected store's frame `RbFrame`, as it was before that edge.
  - `RbFrame` ≥ NumFrames returns all zeros with `RbValid`=1.
  - Back-to-back requests are allowed, one per cycle.
  - `RbValid` drops in the cycle after a cycle with no request; `RbData` holds its last value.
- `ConfigBits_N` is always `~ConfigBits`, with no skew cycle.

## Timing
- Reset (async assert, sync release):
  - shadow = 0, active = 0, `strb_q` = 0
  - `ConfigBits` = 0, `ConfigBits_N` = all 1
  - `LoadedMask` = 0, `AllLoaded` = 0, `StrobeErr` = 0, `RbValid` = 0, `RbData` = 0
- Strobe held high through reset release: `strb_q` = 0, so the first edge after release counts as a rising edge and writes.
- Write latency: the shadow frame and `LoadedMask` are visible 1 cycle after the rising-edge sample.
- Commit latency: `ConfigBits` changes on the edge sampling `Commit` and is visible the following cycle. No intermediate mixed image is ever output.
- Readback latency: 1 cycle. Reading a frame on the edge it is written returns the old value.
- Reset asserted mid-load or mid-commit: all state returns to reset values immediately. A partial commit is impossible.
- All outputs are registered, except `ConfigBits_N` and `AllLoaded`, which are pure decodes of registers.

## Test plan
- Reset, then strobe frames 0..19 one at a time with data 0xA5A50000+f, then `Commit`:
  - `AllLoaded`=1 before commit.
  - After commit, `ConfigBits[32f+:32]` = 0xA5A50000+f, `ConfigBits_N` is the inverse, and `LoadedMask`=0.
- Hold `FrameStrobe[3]` high for 5 cycles while `FrameData` changes each cycle: only the first-cycle data is stored in shadow frame 3.
- Rise `FrameStrobe[2]` and `FrameStrobe[7]` together:
  - No shadow change and `StrobeErr`=1, held until a `ClearErr` pulse.
  - `ClearErr` coincident with a new multi-hot edge leaves `StrobeErr`=1.
- Write frame 5 = 0x1 in the same cycle as `Commit`:
  - active frame 5 keeps its old value; shadow frame 5 = 0x1; `LoadedMask` = only bit 5.
  - A second `Commit` then drives `ConfigBits[160+:32]`=0x1.
- Readback stream: `RbReq` for 3 consecutive cycles with `RbFrame`=0/1/25 and `RbSel`=1 → `RbValid`=1 for 3 cycles with data active0, active1, 0.
- `NoConfigBits`=40, `FrameBitsPerRow`=32:
  - Write frame 1 = 0xFFFFFFFF → only `ConfigBits[39:32]` set; readback of shadow frame 1 = 0x000000FF.
  - Assert `resetn` low mid-sequence → all outputs return to reset values without waiting for a clock.

Source files
------------

// File: rtl/tile_config_mem_sync.sv
// Double-buffered tile configuration memory: frames are written into a shadow store on
// strobe rising edges, and a Commit pulse copies the whole shadow image to the active store.
module tile_config_mem_sync #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned NoConfigBits    = 640,
  parameter int unsigned RbIdxW          = $clog2(MaxFramesPerCol),
  localparam int unsigned NumFrames      = (NoConfigBits + FrameBitsPerRow - 1) / FrameBitsPerRow
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  input  logic                       Commit,
  input  logic                       ClearErr,
  input  logic                       RbReq,
  input  logic [RbIdxW-1:0]          RbFrame,
  input  logic                       RbSel,
  output logic [NoConfigBits-1:0]    ConfigBits,
  output logic [NoConfigBits-1:0]    ConfigBits_N,
  output logic [NumFrames-1:0]       LoadedMask,
  output logic                       AllLoaded,
  output logic                       StrobeErr,
  output logic                       RbValid,
  output logic [FrameBitsPerRow-1:0] RbData
);

  logic [NumFrames-1:0]       r_strb;
  logic [NoConfigBits-1:0]    r_shadow;
  logic [NoConfigBits-1:0]    r_active;
  logic [NumFrames-1:0]       r_loaded;
  logic                       r_err;
  logic                       r_rb_valid;
  logic [FrameBitsPerRow-1:0] r_rb_data;

  logic [NumFrames-1:0]       w_rise;
  logic                       w_multi;
  logic [NumFrames-1:0]       w_wr_sel;
  logic [NoConfigBits-1:0]    w_shadow_d;
  logic [FrameBitsPerRow-1:0] w_sh_frm [NumFrames];
  logic [FrameBitsPerRow-1:0] w_ac_frm [NumFrames];
  logic [FrameBitsPerRow-1:0] w_rb_data;

  // Only strobe lines that map to a real frame take part in edge detection.
  assign w_rise   = FrameStrobe[NumFrames-1:0] & ~r_strb;
  assign w_multi  = |(w_rise & (w_rise - NumFrames'(1)));
  assign w_wr_sel = w_multi ? '0 : w_rise;

  for (genvar i = 0; i < NoConfigBits; i++) begin : g_bit
    localparam int unsigned F = i / FrameBitsPerRow;
    localparam int unsigned B = i % FrameBitsPerRow;
    assign w_shadow_d[i] = w_wr_sel[F] ? FrameData[B] : r_shadow[i];
  end

  // Frame-shaped views of both stores; bits past NoConfigBits read as zero.
  for (genvar f = 0; f < NumFrames; f++) begin : g_frm
    for (genvar b = 0; b < FrameBitsPerRow; b++) begin : g_frm_bit
      localparam int unsigned Idx = f * FrameBitsPerRow + b;
      if (Idx < NoConfigBits) begin : g_real
        assign w_sh_frm[f][b] = r_shadow[Idx];
        assign w_ac_frm[f][b] = r_active[Idx];
      end else begin : g_pad
        assign w_sh_frm[f][b] = 1'b0;
        assign w_ac_frm[f][b] = 1'b0;
      end
    end
  end

  always_comb begin
    w_rb_data = '0;
    for (int f = 0; f < NumFrames; f++) begin
      if (RbFrame == RbIdxW'(f)) begin
        w_rb_data = RbSel ? w_ac_frm[f] : w_sh_frm[f];
      end
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_strb     <= '0;
      r_shadow   <= '0;
      r_active   <= '0;
      r_loaded   <= '0;
      r_err      <= 1'b0;
      r_rb_valid <= 1'b0;
      r_rb_data  <= '0;
    end else begin
      r_strb   <= FrameStrobe[NumFrames-1:0];
      r_shadow <= w_shadow_d;
      // Active takes the pre-edge shadow, so a same-cycle write lands in shadow only.
      if (Commit) begin
        r_active <= r_shadow;
      end
      r_loaded <= Commit ? w_wr_sel : (r_loaded | w_wr_sel);
      if (w_multi) begin
        r_err <= 1'b1;
      end else if (ClearErr) begin
        r_err <= 1'b0;
      end
      r_rb_valid <= RbReq;
      if (RbReq) begin
        r_rb_data <= w_rb_data;
      end
    end
  end

  assign ConfigBits   = r_active;
  assign ConfigBits_N = ~r_active;
  assign LoadedMask   = r_loaded;
  assign AllLoaded    = &r_loaded;
  assign StrobeErr    = r_err;
  assign RbValid      = r_rb_valid;
  assign RbData       = r_rb_data;

endmodule

// File: tb/tb_tile_config_mem_sync.sv
// Directed bench for tile_config_mem_sync: a full-size tile plus a 40-bit tile sharing stimulus.
module tb_tile_config_mem_sync;

  logic        CLK;
  logic        resetn;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic        Commit;
  logic        ClearErr;
  logic        RbReq;
  logic [4:0]  RbFrame;
  logic        RbSel;

  logic [639:0] ConfigBits;
  logic [639:0] ConfigBits_N;
  logic [19:0]  LoadedMask;
  logic         AllLoaded;
  logic         StrobeErr;
  logic         RbValid;
  logic [31:0]  RbData;

  logic [39:0]  b_ConfigBits;
  logic [39:0]  b_ConfigBits_N;
  logic [1:0]   b_LoadedMask;
  logic         b_AllLoaded;
  logic         b_StrobeErr;
  logic         b_RbValid;
  logic [31:0]  b_RbData;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [639:0] exp_cfg;

  tile_config_mem_sync dut (
    .CLK          (CLK),
    .resetn       (resetn),
    .FrameData    (FrameData),
    .FrameStrobe  (FrameStrobe),
    .Commit       (Commit),
    .ClearErr     (ClearErr),
    .RbReq        (RbReq),
    .RbFrame      (RbFrame),
    .RbSel        (RbSel),
    .ConfigBits   (ConfigBits),
    .ConfigBits_N (ConfigBits_N),
    .LoadedMask   (LoadedMask),
    .AllLoaded    (AllLoaded),
    .StrobeErr    (StrobeErr),
    .RbValid      (RbValid),
    .RbData       (RbData)
  );

  tile_config_mem_sync #(.NoConfigBits(40)) dut_b (
    .CLK          (CLK),
    .resetn       (resetn),
    .FrameData    (FrameData),
    .FrameStrobe  (FrameStrobe),
    .Commit       (Commit),
    .ClearErr     (ClearErr),
    .RbReq        (RbReq),
    .RbFrame      (RbFrame),
    .RbSel        (RbSel),
    .ConfigBits   (b_ConfigBits),
    .ConfigBits_N (b_ConfigBits_N),
    .LoadedMask   (b_LoadedMask),
    .AllLoaded    (b_AllLoaded),
    .StrobeErr    (b_StrobeErr),
    .RbValid      (b_RbValid),
    .RbData       (b_RbData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    resetn = 1'b0; FrameData = '0; FrameStrobe = '0; Commit = 1'b0; ClearErr = 1'b0;
    RbReq = 1'b0; RbFrame = '0; RbSel = 1'b0;
    exp_cfg = '0;
    #3;
    chk("rst_cfg", ConfigBits, '0);
    chk("rst_cfg_n", ConfigBits_N, {640{1'b1}});
    chk("rst_mask", LoadedMask, '0);
    chk("rst_all", AllLoaded, 1'b0);
    chk("rst_err", StrobeErr, 1'b0);
    chk("rst_rbv", RbValid, 1'b0);
    chk("rst_rbd", RbData, '0);
    tick();
    resetn = 1'b1;

    // Load every frame, one strobe at a time.
    for (int f = 0; f < 20; f++) begin
      FrameStrobe = 20'(1) << f;
      FrameData   = 32'hA5A5_0000 + 32'(f);
      exp_cfg[32*f +: 32] = 32'hA5A5_0000 + 32'(f);
      tick();
    end
    FrameStrobe = '0;
    tick();
    chk("all_mask", LoadedMask, 20'hF_FFFF);
    chk("all_loaded", AllLoaded, 1'b1);
    chk("precommit_cfg", ConfigBits, '0);

    Commit = 1'b1;
    tick();
    Commit = 1'b0;
    for (int f = 0; f < 20; f += 7) begin
      chk($sformatf("commit_frame%0d", f), ConfigBits[32*f +: 32], 32'hA5A5_0000 + 32'(f));
    end
    chk("commit_cfg", ConfigBits, exp_cfg);
    chk("commit_cfg_n", ConfigBits_N, ~exp_cfg);
    chk("commit_mask", LoadedMask, '0);
    chk("commit_all", AllLoaded, 1'b0);

    // Strobe 3 held high: only the first cycle's data is captured.
    FrameStrobe = 20'h8;
    for (int i = 0; i < 5; i++) begin
      FrameData = 32'h1111_1111 * 32'(i + 1);
      tick();
      if (i == 0) chk("hold_mask", LoadedMask, 20'h8);
    end
    FrameStrobe = '0;
    RbReq = 1'b1; RbSel = 1'b0; RbFrame = 5'd3;
    tick();
    RbReq = 1'b0;
    chk("hold_rbv", RbValid, 1'b1);
    chk("hold_rbd", RbData, 32'h1111_1111);
    tick();
    chk("idle_rbv", RbValid, 1'b0);
    chk("idle_rbd_hold", RbData, 32'h1111_1111);

    // Multi-hot rising edge.
    FrameStrobe = 20'h84; FrameData = 32'hDEAD_BEEF;
    tick();
    FrameStrobe = '0;
    chk("multi_err", StrobeErr, 1'b1);
    chk("multi_mask", LoadedMask, 20'h8);
    RbReq = 1'b1; RbSel = 1'b0; RbFrame = 5'd2;
    tick();
    chk("multi_sh2", RbData, 32'hA5A5_0002);
    RbFrame = 5'd7;
    tick();
    RbReq = 1'b0;
    chk("multi_sh7", RbData, 32'hA5A5_0007);
    chk("err_sticky", StrobeErr, 1'b1);
    ClearErr = 1'b1;
    tick();
    ClearErr = 1'b0;
    chk("err_cleared", StrobeErr, 1'b0);
    ClearErr = 1'b1; FrameStrobe = 20'h84;
    tick();
    ClearErr = 1'b0; FrameStrobe = '0;
    chk("err_wins", StrobeErr, 1'b1);
    ClearErr = 1'b1;
    tick();
    ClearErr = 1'b0;
    chk("err_cleared2", StrobeErr, 1'b0);

    // Write frame 5 in the same cycle as Commit.
    FrameStrobe = 20'h20; FrameData = 32'h1; Commit = 1'b1;
    tick();
    FrameStrobe = '0; Commit = 1'b0;
    exp_cfg[96 +: 32] = 32'h1111_1111;
    chk("wc_cfg", ConfigBits, exp_cfg);
    chk("wc_mask", LoadedMask, 20'h20);
    RbReq = 1'b1; RbSel = 1'b0; RbFrame = 5'd5;
    tick();
    chk("wc_sh5", RbData, 32'h1);
    RbSel = 1'b1;
    tick();
    RbReq = 1'b0;
    chk("wc_ac5", RbData, 32'hA5A5_0005);
    Commit = 1'b1;
    tick();
    Commit = 1'b0;
    exp_cfg[160 +: 32] = 32'h1;
    chk("wc2_cfg", ConfigBits, exp_cfg);
    chk("wc2_mask", LoadedMask, '0);

    // Back-to-back readback of the active store.
    RbReq = 1'b1; RbSel = 1'b1; RbFrame = 5'd0;
    tick();
    chk("rb0_v", RbValid, 1'b1);
    chk("rb0_d", RbData, 32'hA5A5_0000);
    RbFrame = 5'd1;
    tick();
    chk("rb1_v", RbValid, 1'b1);
    chk("rb1_d", RbData, 32'hA5A5_0001);
    RbFrame = 5'd25;
    tick();
    RbReq = 1'b0;
    chk("rb25_v", RbValid, 1'b1);
    chk("rb25_d", RbData, 32'h0);
    tick();
    chk("rb_end_v", RbValid, 1'b0);

    // Partial last frame on the 40-bit tile.
    resetn = 1'b0;
    #1;
    chk("async_rst_cfg", ConfigBits, '0);
    resetn = 1'b1;
    FrameStrobe = 20'h2; FrameData = 32'hFFFF_FFFF;
    tick();
    FrameStrobe = '0; Commit = 1'b1;
    tick();
    Commit = 1'b0;
    exp_cfg = '0;
    exp_cfg[63:32] = 32'hFFFF_FFFF;
    chk("b_cfg", b_ConfigBits, 40'hFF_0000_0000);
    chk("b_cfg_n", b_ConfigBits_N, 40'h00_FFFF_FFFF);
    chk("b_mask", b_LoadedMask, 2'b00);
    chk("a_cfg_f1", ConfigBits, exp_cfg);
    RbReq = 1'b1; RbSel = 1'b0; RbFrame = 5'd1;
    tick();
    chk("b_rb1", b_RbData, 32'h0000_00FF);
    chk("a_rb1", RbData, 32'hFFFF_FFFF);
    RbFrame = 5'd2;
    tick();
    RbReq = 1'b0;
    chk("b_rb2_v", b_RbValid, 1'b1);
    chk("b_rb2_d", b_RbData, 32'h0);

    // Reset mid-commit: everything clears with no clock edge.
    FrameStrobe = 20'h1; FrameData = 32'h1234; RbReq = 1'b1; RbSel = 1'b1; RbFrame = 5'd1;
    tick();
    FrameStrobe = '0; Commit = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_cfg", ConfigBits, '0);
    chk("mid_cfg_n", ConfigBits_N, {640{1'b1}});
    chk("mid_mask", LoadedMask, '0);
    chk("mid_rbv", RbValid, 1'b0);
    chk("mid_rbd", RbData, '0);
    chk("mid_b_cfg_n", b_ConfigBits_N, 40'hFF_FFFF_FFFF);
    chk("mid_b_rbd", b_RbData, '0);

    // Strobe held high through reset release writes on the first edge.
    Commit = 1'b0; RbReq = 1'b0;
    FrameStrobe = 20'h10; FrameData = 32'hCAFE_0004;
    tick();
    resetn = 1'b1;
    tick();
    chk("rel_mask", LoadedMask, 20'h10);
    chk("rel_cfg", ConfigBits, '0);
    chk("rel_b_mask", b_LoadedMask, 2'b00);
    RbReq = 1'b1; RbSel = 1'b0; RbFrame = 5'd4;
    tick();
    RbReq = 1'b0;
    chk("rel_rb4", RbData, 32'hCAFE_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
